// File: rtl/led_matrix_scanner_pkg.sv
// Shared constants and scan FSM encoding for the 6x6 LED matrix scanner.
// The state encoding is also consumed by the game control unit debug output.
package led_matrix_scanner_pkg;

    localparam int ROWS    = 6;
    localparam int COLS    = 6;
    localparam int FRAME_W = ROWS * COLS;
    localparam int ROW_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/sga_frame_buffer.sv
// Pending/active double buffer. The active frame only changes on the swap
// strobe, so a displayed frame is always shown whole.
module sga_frame_buffer
    import led_matrix_scanner_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_load,
    input  logic               swap,
    output logic               frame_pending,
    output logic [FRAME_W-1:0] active_next
);

    logic [FRAME_W-1:0] pending_q;
    logic [FRAME_W-1:0] pending_n;
    logic [FRAME_W-1:0] active_q;
    logic               pend_flag_n;

    // A load landing on the swap cycle bypasses the pending buffer entirely.
    always_comb begin
        pending_n   = pending_q;
        pend_flag_n = frame_pending;
        active_next = active_q;
        if (swap) begin
            pend_flag_n = 1'b0;
            if (frame_load) begin
                active_next = frame_in;
            end else if (frame_pending) begin
                active_next = pending_q;
            end
        end else if (frame_load) begin
            pending_n   = frame_in;
            pend_flag_n = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q     <= '0;
            active_q      <= '0;
            frame_pending <= 1'b0;
        end else begin
            pending_q     <= pending_n;
            active_q      <= active_next;
            frame_pending <= pend_flag_n;
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed 6x6 LED matrix scanner: blank, then drive each row in turn,
// swapping in a newly loaded frame only at the start of row 0.
module led_matrix_scanner
    import led_matrix_scanner_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_load,
    output logic               frame_pending,
    output logic [ROWS-1:0]    row_sel,
    output logic [COLS-1:0]    col_data,
    output logic               frame_sync,
    output logic [ROW_W-1:0]   db_row
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

    scan_state_t        state_q, state_n;
    logic [ROW_W-1:0]   row_q, row_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [ROWS-1:0]    row_sel_n;
    logic [COLS-1:0]    col_data_n;
    logic               frame_sync_n;
    logic [FRAME_W-1:0] active_next;

    // The swap strobe is the registered frame_sync, i.e. the first BLANK cycle of row 0.
    sga_frame_buffer u_frame_buffer (
        .clock         (clock),
        .reset_n       (reset_n),
        .frame_in      (frame_in),
        .frame_load    (frame_load),
        .swap          (frame_sync),
        .frame_pending (frame_pending),
        .active_next   (active_next)
    );

    always_comb begin
        state_n = state_q;
        row_n   = row_q;
        cnt_n   = cnt_q;
        if (!enable) begin
            state_n = ST_IDLE;
            row_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_n = ST_BLANK;
                    row_n   = '0;
                    cnt_n   = '0;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_n = ST_DRIVE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_n = ST_BLANK;
                        cnt_n   = '0;
                        row_n   = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    row_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end

        // Outputs are computed from next-state values so they can be registered
        // without lagging the FSM; active_next covers a swap on this same edge.
        row_sel_n    = '0;
        col_data_n   = '0;
        frame_sync_n = (state_n == ST_BLANK) && (row_n == '0) && (cnt_n == '0);
        if (state_n == ST_DRIVE) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                if (row_n == ROW_W'(r)) begin
                    row_sel_n[r] = 1'b1;
                    col_data_n   = active_next[r*COLS +: COLS];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            cnt_q      <= '0;
            row_sel    <= '0;
            col_data   <= '0;
            frame_sync <= 1'b0;
        end else begin
            state_q    <= state_n;
            row_q      <= row_n;
            cnt_q      <= cnt_n;
            row_sel    <= row_sel_n;
            col_data   <= col_data_n;
            frame_sync <= frame_sync_n;
        end
    end

    assign db_row = row_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with DWELL_CYCLES=4, BLANK_CYCLES=2.
module tb_led_matrix_scanner;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic [35:0] frame_in;
    logic        frame_load;
    logic        frame_pending;
    logic [5:0]  row_sel;
    logic [5:0]  col_data;
    logic        frame_sync;
    logic [2:0]  db_row;

    int checks = 0;
    int errors = 0;
    int ph     = 0;

    localparam logic [35:0] F1 = 36'h000000FC0;
    localparam logic [35:0] FA = 36'h123456789;
    localparam logic [35:0] FB = 36'hFEDCBA987;
    localparam logic [35:0] FC = 36'h0F0F0F0F0;
    localparam logic [35:0] FD = 36'h3C30C3C30;
    localparam logic [35:0] FE = 36'hABCDEF123;

    led_matrix_scanner #(
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .frame_in      (frame_in),
        .frame_load    (frame_load),
        .frame_pending (frame_pending),
        .row_sel       (row_sel),
        .col_data      (col_data),
        .frame_sync    (frame_sync),
        .db_row        (db_row)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        en;
        logic        load;
        logic [35:0] fin;
        logic [5:0]  rs;
        logic [5:0]  cd;
        logic        fs;
        logic [2:0]  db;
        logic        fp;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_row_sel"}, row_sel, 6'h00);
        chk({tag, "_col_data"}, col_data, 6'h00);
        chk({tag, "_frame_sync"}, frame_sync, 1'b0);
        chk({tag, "_db_row"}, db_row, 3'd0);
    endtask

    // Expected scan outputs derived from the phase within the 36-cycle frame.
    task automatic check_phase(input logic [35:0] f);
        int         row;
        int         o;
        logic [5:0] one;
        logic [5:0] exp_rs;
        logic [5:0] exp_cd;
        row    = ph / 6;
        o      = ph % 6;
        one    = 6'd1;
        exp_rs = (o >= 2) ? (one << row) : 6'h00;
        exp_cd = (o >= 2) ? f[row*6 +: 6] : 6'h00;
        chk($sformatf("row_sel@ph%0d", ph), row_sel, exp_rs);
        chk($sformatf("col_data@ph%0d", ph), col_data, exp_cd);
        chk($sformatf("frame_sync@ph%0d", ph), frame_sync, (ph == 0) ? 1'b1 : 1'b0);
        chk($sformatf("db_row@ph%0d", ph), db_row, row[2:0]);
    endtask

    task automatic step(input logic [35:0] f);
        tick();
        ph = (ph + 1) % 36;
        check_phase(f);
    endtask

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b0;
        frame_in   = '0;
        frame_load = 1'b0;

        vecs[0]  = '{1'b1, 1'b1, F1, 6'h00, 6'h00, 1'b1, 3'd0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, F1, 6'h00, 6'h00, 1'b0, 3'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, F1, 6'h01, 6'h00, 1'b0, 3'd0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, F1, 6'h01, 6'h00, 1'b0, 3'd0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, F1, 6'h01, 6'h00, 1'b0, 3'd0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, F1, 6'h01, 6'h00, 1'b0, 3'd0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, F1, 6'h00, 6'h00, 1'b0, 3'd1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, F1, 6'h00, 6'h00, 1'b0, 3'd1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, F1, 6'h02, 6'h3F, 1'b0, 3'd1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, F1, 6'h02, 6'h3F, 1'b0, 3'd1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, F1, 6'h02, 6'h3F, 1'b0, 3'd1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, F1, 6'h02, 6'h3F, 1'b0, 3'd1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, F1, 6'h00, 6'h00, 1'b0, 3'd2, 1'b0};
        vecs[13] = '{1'b1, 1'b0, F1, 6'h00, 6'h00, 1'b0, 3'd2, 1'b0};
        vecs[14] = '{1'b1, 1'b0, F1, 6'h04, 6'h00, 1'b0, 3'd2, 1'b0};

        // Reset state, then idle with enable low after release
        tick();
        tick();
        check_idle("reset");
        chk("reset_frame_pending", frame_pending, 1'b0);
        reset_n = 1'b1;
        tick();
        check_idle("idle");

        // First frame: load with enable, table-driven through row 2
        for (int i = 0; i < 15; i++) begin
            enable     = vecs[i].en;
            frame_load = vecs[i].load;
            frame_in   = vecs[i].fin;
            tick();
            chk($sformatf("v%0d_row_sel", i), row_sel, vecs[i].rs);
            chk($sformatf("v%0d_col_data", i), col_data, vecs[i].cd);
            chk($sformatf("v%0d_frame_sync", i), frame_sync, vecs[i].fs);
            chk($sformatf("v%0d_db_row", i), db_row, vecs[i].db);
            chk($sformatf("v%0d_frame_pending", i), frame_pending, vecs[i].fp);
        end
        frame_load = 1'b0;
        ph = 14;

        // Two more full frame periods: sync every 36 cycles, blank/drive pattern
        for (int i = 0; i < 72; i++) step(F1);

        // Load A mid-frame; F1 continues whole, A appears after next sync
        while (ph != 3) step(F1);
        frame_in   = FA;
        frame_load = 1'b1;
        step(F1);
        frame_load = 1'b0;
        chk("A_pending_set", frame_pending, 1'b1);
        while (ph != 35) step(F1);
        chk("A_pending_before_sync", frame_pending, 1'b1);
        step(FA);
        chk("A_pending_at_sync", frame_pending, 1'b1);
        step(FA);
        chk("A_pending_cleared", frame_pending, 1'b0);

        // Load B mid-frame A; A stays until the following sync
        while (ph != 15) step(FA);
        frame_in   = FB;
        frame_load = 1'b1;
        step(FA);
        frame_load = 1'b0;
        chk("B_pending_set", frame_pending, 1'b1);
        while (ph != 35) step(FA);
        step(FB);

        // C pending, then D loaded on the sync cycle: D wins, C dropped
        while (ph != 20) step(FB);
        frame_in   = FC;
        frame_load = 1'b1;
        step(FB);
        frame_load = 1'b0;
        chk("C_pending_set", frame_pending, 1'b1);
        while (ph != 35) step(FB);
        step(FD);
        frame_in   = FD;
        frame_load = 1'b1;
        step(FD);
        frame_load = 1'b0;
        chk("D_collision_pending", frame_pending, 1'b0);
        while (ph != 35) step(FD);
        step(FD);
        chk("D_repeat_pending", frame_pending, 1'b0);
        step(FD);

        // Drop enable during DRIVE row 3, load E while disabled, re-enable
        while (ph != 20) step(FD);
        chk("row3_drive_seen", row_sel, 6'h08);
        enable = 1'b0;
        tick();
        check_idle("disable");
        frame_in   = FE;
        frame_load = 1'b1;
        tick();
        frame_load = 1'b0;
        check_idle("disabled_load");
        chk("E_pending_while_disabled", frame_pending, 1'b1);
        enable = 1'b1;
        ph = 35;
        step(FE);
        chk("E_pending_at_resync", frame_pending, 1'b1);
        while (ph != 35) step(FE);
        chk("E_pending_cleared", frame_pending, 1'b0);

        // Asynchronous reset mid-DRIVE clears outputs and the active frame
        step(FE);
        while (ph != 9) step(FE);
        chk("row1_drive_seen", row_sel, 6'h02);
        #2;
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        check_idle("async_reset");
        chk("async_reset_frame_pending", frame_pending, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check_idle("post_reset_idle");
        enable = 1'b1;
        ph = 35;
        step(36'h0);
        while (ph != 35) step(36'h0);
        chk("post_reset_pending", frame_pending, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_matrix_scanner.md
LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

Interface
REQ-001 Parameter DWELL_CYCLES, default 50000, clock cycles each row is driven (>=1).
REQ-002 Parameter BLANK_CYCLES, default 500, clock cycles of all-off between rows (>=1).
REQ-003 clock  input  1  single system clock, all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  scanning enabled when high.
REQ-006 frame_in  input  36  6x6 LED frame from game datapath; bit r*6+c = row r, column c.
REQ-007 frame_load  input  1  one-cycle strobe: capture frame_in into pending buffer.
REQ-008 frame_pending  output  1  pending buffer holds a frame not yet displayed.
REQ-009 row_sel  output  6  one-hot active row drive, bit r = row r.
REQ-010 col_data  output  6  column drive for the selected row, bit c = column c.
REQ-011 frame_sync  output  1  one-cycle pulse at start of each displayed frame.
REQ-012 db_row  output  3  current row index 0..5, debug.

Function
REQ-013 FSM states: IDLE, BLANK, DRIVE; row index 0..5; one cycle counter, width clog2(max(DWELL_CYCLES,BLANK_CYCLES)).
REQ-014 IDLE: row_sel=0, col_data=0, row index=0; enable high -> BLANK row 0 next cycle.
REQ-015 BLANK: row_sel=0, col_data=0 for exactly BLANK_CYCLES cycles, then DRIVE same row.
REQ-016 DRIVE: row_sel=one-hot(row), col_data=active[row*6+:6] for exactly DWELL_CYCLES cycles, then BLANK of row+1; after row 5, wraps to row 0.
REQ-017 Frame period = 6*(BLANK_CYCLES+DWELL_CYCLES) cycles; no row is skipped or repeated.
REQ-018 All outputs registered; row_sel and col_data never non-zero in same cycle as a row transition (blank always separates rows).
REQ-019 frame_load at any time: pending<=frame_in, frame_pending<=1 next cycle; later load before swap overwrites pending (last wins).
REQ-020 Swap occurs on entry to BLANK row 0 (first cycle): if frame_pending, active<=pending, frame_pending<=0; frame_sync=1 that cycle.
REQ-021 frame_load coincident with swap cycle: active<=frame_in directly, frame_pending<=0; prior pending discarded.
REQ-022 Active buffer never changes mid-frame; a frame is displayed whole or not at all.
REQ-023 No pending frame at swap: active retained, frame repeats.
REQ-024 enable low in any state: IDLE next cycle, outputs zero, row index 0, pending/active retained; frame_load still accepted.
REQ-025 Re-enable: restart at BLANK row 0 with swap rule and frame_sync.

Reset
REQ-026 reset_n low: state IDLE, row index 0, counter 0, active=0, pending=0, frame_pending=0, row_sel=0, col_data=0, frame_sync=0, db_row=0, asynchronously.
REQ-027 Reset release mid-frame: scanning restarts from BLANK row 0 only once enable high; no partial-row output.

Structure
REQ-028 Shared package holds ROWS=6, COLS=6, FRAME_W=36 and the FSM state encoding shared with the game control unit debug output.
REQ-029 One sub-module natural: sga_frame_buffer (pending/active double buffer with swap and load-collision rule); the scanner FSM lives in the top.

Verification (DWELL_CYCLES=4, BLANK_CYCLES=2, period 36 cycles)
REQ-030 Reset, enable=1, load 36'h000000FC0 -> frame_sync at first BLANK; row 1 DRIVE shows row_sel=6'b000010, col_data=6'h3F for 4 cycles; other rows col_data=0.
REQ-031 Count cycles enable high -> frame_sync pulses exactly every 36 cycles; each row: 2 cycles all-zero then 4 cycles one-hot.
REQ-032 Load frame A, then frame B at mid-frame -> A shown whole until next frame_sync, then B; frame_pending 1 between load and swap.
REQ-033 frame_load coincident with frame_sync cycle, pending held C, frame_in=D -> D displayed that frame, frame_pending=0.
REQ-034 enable dropped during DRIVE row 3 -> next cycle row_sel=0, col_data=0, db_row=0; re-enable -> frame_sync and BLANK row 0.
REQ-035 reset_n pulsed low mid-DRIVE -> outputs zero immediately (no clock edge needed), active buffer cleared.
